// File: rtl/muldiv_if.sv
// Control/data bundle between the CU/ALU path and the multiply/divide unit.
`timescale 1ns/1ps
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             mf_rd;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    output mf_rd, mthi, mtlo, wdata,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    input  mf_rd, mthi, mtlo, wdata,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div_q, div_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               sgn;
  logic               is_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum, shl, dif;
  logic [2*WIDTH-1:0] prod_mul, prod_div, mres;
  logic [WIDTH-1:0]   quo, rem;

  assign sgn    = ~bus.op[0];
  assign is_div = bus.op[1];

  always_comb begin
    abs_a = bus.a;
    abs_b = bus.b;
    if (sgn && bus.a[WIDTH-1]) abs_a = -bus.a;
    if (sgn && bus.b[WIDTH-1]) abs_b = -bus.b;
  end

  // Multiply: product low half holds the unconsumed multiplier bits.
  always_comb begin
    msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
         + {1'b0, opnd_q & {WIDTH{prod_q[0]}}};
    prod_mul = {msum, prod_q[WIDTH-1:1]};
  end

  // Divide: high half is the partial remainder, low half the quotient.
  always_comb begin
    shl = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    dif = shl - {1'b0, opnd_q};
    if (dif[WIDTH])
      prod_div = {shl[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    else
      prod_div = {dif[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    mres = neg_q ? -prod_q : prod_q;
    quo  = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem  = rneg_q ? -prod_q[2*WIDTH-1:WIDTH]
                  : prod_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!bus.flush) begin
            opnd_d  = is_div ? abs_b : abs_a;
            prod_d  = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
            neg_d   = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg_d  = sgn & bus.a[WIDTH-1];
            div_d   = is_div;
            dz_d    = is_div && (bus.b == '0);
            cnt_d   = '0;
            state_d = CALC;
            // Zero divisor keeps the raw dividend for HI.
            if (is_div && (bus.b == '0)) begin
              prod_d  = {{WIDTH{1'b0}}, bus.a};
              state_d = FIX;
            end
          end
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          prod_d = div_q ? prod_div : prod_mul;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          unique case (1'b1)
            dz_q: begin
              hi_d = prod_q[WIDTH-1:0];
              lo_d = '1;
            end
            (div_q && !dz_q): begin
              hi_d = rem;
              lo_d = quo;
            end
            (!div_q): begin
              {hi_d, lo_d} = mres;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = bus.busy
                   & (bus.start | bus.mf_rd | bus.mthi | bus.mtlo);
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model, per-cycle compare,
// directed corner cases and randomized traffic.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  int         m_left = 0;
  bit         m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] p_hi = '0, p_lo = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic void ref_calc(input logic [1:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   output logic [W-1:0] h,
                                   output logic [W-1:0] l);
    longint sp;
    logic [63:0] up;
    h = '0;
    l = '0;
    case (o)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {h, l} = sp;
      end
      2'd1: begin
        up = {32'b0, x} * {32'b0, y};
        {h, l} = up;
      end
      2'd2: begin
        if (y == 0) begin
          h = x; l = '1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          h = '0; l = 32'h8000_0000;
        end else begin
          l = $signed(x) / $signed(y);
          h = $signed(x) % $signed(y);
        end
      end
      default: begin
        if (y == 0) begin
          h = x; l = '1;
        end else begin
          l = x / y;
          h = x % y;
        end
      end
    endcase
  endfunction

  task automatic model_reset();
    m_left = 0;
    m_done = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (m_left > 0) begin
      if (bus.flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
          m_done = 1'b1;
        end
      end
    end else if (bus.start) begin
      if (!bus.flush) begin
        ref_calc(bus.op, bus.a, bus.b, p_hi, p_lo);
        m_left = (bus.op[1] && bus.b == 0) ? 1 : W + 1;
      end
    end else begin
      if (bus.mthi) m_hi = bus.wdata;
      if (bus.mtlo) m_lo = bus.wdata;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #2;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("busy", bus.busy, m_left > 0);
      chk("done", bus.done, m_done);
      chk("stall", bus.stall, (m_left > 0) &&
          (bus.start || bus.mf_rd || bus.mthi || bus.mtlo));
    end
  end

  task automatic wait_idle(output int bc);
    bc = 0;
    for (int i = 0; i < 40 && m_left > 0; i++) begin
      if (bus.busy) bc++;
      cycle();
    end
    if (m_left > 0) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, output int bc);
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    wait_idle(bc);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  int bc;

  initial begin
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.flush = 0; bus.mf_rd = 0; bus.mthi = 0; bus.mtlo = 0;
    bus.wdata = 0;
    cycle();
    cycle();
    chk_en = 1'b1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset_n = 1'b1;
    cycle();

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("multu_done", bus.done, 1);
    chk("multu_busy_cycles", bc, 33);

    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, bc);
    chk("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", bus.lo, 32'hFFFF_FFF1);

    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, bc);
    chk("mult_min_hi", bus.hi, 32'h4000_0000);
    chk("mult_min_lo", bus.lo, 32'h0);

    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, bc);
    chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(2'd3, 32'd100, 32'd7, bc);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'h0);

    run_op(2'd3, 32'h1234, 32'h0, bc);
    chk("dz_done", bus.done, 1);
    chk("dz_busy_cycles", bc, 1);
    chk("dz_hi", bus.hi, 32'h1234);
    chk("dz_lo", bus.lo, 32'hFFFF_FFFF);

    // Stall, ignored MTHI and ignored restart while busy.
    bus.op = 2'd0; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && m_left > 0; i++) begin
      if (i == 4) bus.mf_rd = 1'b1;
      if (i == 5) chk("stall_busy", bus.stall, 1);
      if (i == 6) begin bus.mthi = 1'b1; bus.wdata = 32'hDEAD; end
      if (i == 7) bus.mthi = 1'b0;
      if (i == 9) begin
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 9; bus.b = 3;
      end
      if (i == 10) bus.start = 1'b0;
      cycle();
    end
    chk("stall_done_cycle", bus.stall, 0);
    chk("stall_op_hi", bus.hi, 32'd0);
    chk("stall_op_lo", bus.lo, 32'd42);
    bus.mf_rd = 1'b0;

    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hAAAA_5555;
    cycle();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("mt_both_hi", bus.hi, 32'hAAAA_5555);
    chk("mt_both_lo", bus.lo, 32'hAAAA_5555);

    bus.mthi = 1'b1; bus.wdata = 32'h77;
    bus.op = 2'd1; bus.a = 2; bus.b = 3; bus.start = 1'b1;
    cycle();
    bus.mthi = 1'b0; bus.start = 1'b0;
    wait_idle(bc);
    chk("start_wins_hi", bus.hi, 32'd0);
    chk("start_wins_lo", bus.lo, 32'd6);

    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h1357_9BDF;
    cycle();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.op = 2'd2; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (9) cycle();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_hi", bus.hi, 32'h1357_9BDF);
    chk("flush_lo", bus.lo, 32'h1357_9BDF);
    repeat (40) cycle();

    bus.flush = 1'b1; bus.start = 1'b1;
    bus.op = 2'd1; bus.a = 5; bus.b = 5;
    cycle();
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("flush_start_busy", bus.busy, 0);
    cycle();

    bus.op = 2'd0; bus.a = 32'd11; bus.b = 32'd13; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (10) cycle();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_hi", bus.hi, 0);
    chk("async_rst_lo", bus.lo, 0);
    chk("async_rst_busy", bus.busy, 0);
    cycle();
    reset_n = 1'b1;
    cycle();

    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 4) == 0);
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = pick();
      bus.b     = pick();
      bus.flush = ($urandom_range(0, 60) == 0);
      bus.mf_rd = ($urandom_range(0, 3) == 0);
      bus.mthi  = ($urandom_range(0, 9) == 0);
      bus.mtlo  = ($urandom_range(0, 9) == 0);
      bus.wdata = $urandom;
      cycle();
    end
    bus.start = 0; bus.flush = 0; bus.mf_rd = 0;
    bus.mthi = 0; bus.mtlo = 0;
    wait_idle(bc);
    cycle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
